// File: rtl/usb_pkt_validator.sv
// usb_pkt_validator
//   Validates a received USB data packet (PID check, then optional bit-serial
//   CRC16 check over the 64-bit payload) and presents the payload to a
//   downstream consumer with a valid/ready handshake.
//
//   Optional feature macro: USB_CRC16_CHECK_EN
//     defined   : CHECK state runs the CRC16 over 64 cycles (blk_valid 66
//                 cycles after pkt_done).
//     undefined : a valid PID goes straight to HOLD (blk_valid 2 cycles after
//                 pkt_done); crc_err is tied low and no CRC logic exists.
//
//   Ports
//     clk        in   system clock, rising edge
//     n_rst      in   synchronous reset, active HIGH despite the name
//     pkt_done   in   one-cycle strobe, packet fields valid in that cycle
//     rcv_pid    in   [7:0]  received PID
//     rcv_crc16  in   [15:0] received CRC16, bit 0 first on the wire
//     rcv_data   in   [63:0] received payload, bit 0 first on the wire
//     blk_ready  in   downstream can accept the block
//     blk_valid  out  blk_data holds a validated block
//     blk_data   out  [63:0] validated payload (zero when not valid)
//     pid_err    out  one-cycle pulse, PID rejected
//     crc_err    out  one-cycle pulse, CRC16 mismatch
//     drop_cnt   out  [7:0] saturating count of discarded packets
//     busy       out  FSM not in IDLE
//
//   state | meaning
//   IDLE  | waiting for pkt_done; one cycle later (pend_q) the PID is judged
//   CHECK | shifting payload bits through the CRC16, one bit per cycle
//   HOLD  | presenting blk_data until blk_ready
module usb_pkt_validator (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        pkt_done,
    input  logic [7:0]  rcv_pid,
    input  logic [15:0] rcv_crc16,
    input  logic [63:0] rcv_data,
    input  logic        blk_ready,
    output logic        blk_valid,
    output logic [63:0] blk_data,
    output logic        pid_err,
    output logic        crc_err,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        pend_q, pend_d;
    logic [7:0]  pid_q, pid_d;
    logic [63:0] data_q, data_d;
    logic [7:0]  drop_q, drop_d;
    logic        pid_ok;
    logic        overrun;
    logic        crc_fail;

    assign pid_ok = (pid_q[7:4] == ~pid_q[3:0]) &&
                    ((pid_q[3:0] == 4'b0011) || (pid_q[3:0] == 4'b1011));

`ifdef USB_CRC16_CHECK_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_rx_q, crc_rx_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        crc_bit;
    logic [15:0] crc_step;
    logic [15:0] crc_calc;

    // cnt_q counts down 63..0, so ~cnt_q walks the payload from bit 0 upward
    assign crc_bit  = data_q[~cnt_q];
    assign crc_step = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ crc_bit) ? 16'h8005 : 16'h0000);

    // final CRC is inverted and bit-reversed to match wire order of rcv_crc16
    always_comb begin
        crc_calc = '0;
        for (int i = 0; i < 16; i++) begin
            crc_calc[i] = ~crc_step[15-i];
        end
    end

    assign crc_fail = (state_q == S_CHECK) && (cnt_q == 6'd0) && (crc_calc != crc_rx_q);
`else
    logic unused_crc;
    assign unused_crc = ^rcv_crc16;
    assign crc_fail   = 1'b0;
`endif

    // a strobe is lost whenever a packet is already in flight, including the
    // PID-decision cycle and the handshake cycle
    assign overrun = pkt_done && ((state_q != S_IDLE) || pend_q);

    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        pid_d   = pid_q;
        data_d  = data_q;
`ifdef USB_CRC16_CHECK_EN
        crc_d    = crc_q;
        crc_rx_d = crc_rx_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    if (pid_ok) begin
`ifdef USB_CRC16_CHECK_EN
                        state_d = S_CHECK;
                        crc_d   = 16'hFFFF;
                        cnt_d   = 6'd63;
`else
                        state_d = S_HOLD;
`endif
                    end
                end else if (pkt_done) begin
                    pend_d = 1'b1;
                    pid_d  = rcv_pid;
                    data_d = rcv_data;
`ifdef USB_CRC16_CHECK_EN
                    crc_rx_d = rcv_crc16;
`endif
                end
            end
            S_CHECK: begin
`ifdef USB_CRC16_CHECK_EN
                crc_d = crc_step;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    crc_d   = 16'hFFFF;
                    state_d = crc_fail ? S_IDLE : S_HOLD;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_HOLD: begin
                if (blk_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // simultaneous drop causes count once
        drop_d = drop_q;
        if ((pid_err || crc_fail || overrun) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            pid_q   <= '0;
            data_q  <= '0;
            drop_q  <= '0;
`ifdef USB_CRC16_CHECK_EN
            crc_q    <= 16'hFFFF;
            crc_rx_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pid_q   <= pid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
`ifdef USB_CRC16_CHECK_EN
            crc_q    <= crc_d;
            crc_rx_q <= crc_rx_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign pid_err   = pend_q && !pid_ok;
    assign crc_err   = crc_fail;
    assign blk_valid = (state_q == S_HOLD);
    assign blk_data  = blk_valid ? data_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign drop_cnt  = drop_q;

endmodule

// File: doc/usb_pkt_validator.md
USB_PKT_VALIDATOR -- requirements
Module: usb_pkt_validator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 n_rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 pkt_done  input  1  one-cycle strobe from the receiver; packet fields are stable in that cycle.
REQ-005 rcv_pid  input  8  received PID byte.
REQ-006 rcv_crc16  input  16  received CRC16; bit 0 = first CRC bit on the wire.
REQ-007 rcv_data  input  64  received payload; bit 0 = first data bit on the wire.
REQ-008 blk_ready  input  1  downstream (encryptor) can accept a block.
REQ-009 blk_valid  output  1  blk_data holds a validated block.
REQ-010 blk_data  output  64  validated payload.
REQ-011 pid_err  output  1  one-cycle pulse: PID rejected.
REQ-012 crc_err  output  1  one-cycle pulse: CRC16 mismatch.
REQ-013 drop_cnt  output  8  saturating count of discarded packets.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, CHECK and HOLD.
REQ-016 IDLE + pkt_done: latch rcv_pid, rcv_crc16 and rcv_data in the same edge; evaluate the PID on the latched values the next cycle.
REQ-017 The PID is valid only if pid[7:4] == ~pid[3:0] and pid[3:0] is DATA0 (4'b0011) or DATA1 (4'b1011).
REQ-018 Invalid PID: pulse pid_err for one cycle, increment drop_cnt, return to IDLE without entering CHECK.
REQ-019 Valid PID: enter CHECK with crc_reg = 16'hFFFF.
REQ-020 CHECK processes one data bit per cycle, bit 0 first, for exactly 64 cycles.
REQ-021 CRC16 update per bit: fb = crc_reg[15] ^ bit; shift left by one; XOR 16'h8005 if fb = 1.
REQ-022 After 64 bits: computed CRC bit i = ~crc_reg[15-i].
REQ-023 CRC match: enter HOLD.
REQ-024 CRC mismatch: pulse crc_err for one cycle, increment drop_cnt, return to IDLE.
REQ-025 HOLD: blk_valid = 1 and blk_data = latched payload; both stay stable until blk_valid && blk_ready.
REQ-026 On the handshake edge the block SHALL return to IDLE; blk_valid = 0 the next cycle.
REQ-027 Latency SHALL be: pkt_done at cycle 0, PID decision at cycle 1, CHECK for 64 cycles, blk_valid asserted 66 cycles after pkt_done.
REQ-028 pkt_done while in CHECK or HOLD SHALL be ignored and SHALL increment drop_cnt (overrun); this includes the cycle in which a handshake completes.
REQ-029 drop_cnt SHALL saturate at 8'hFF and never wrap.
REQ-030 If two drop causes occur in the same cycle, drop_cnt SHALL increment by 1 only.
REQ-031 blk_ready is ignored outside HOLD.

Reset
REQ-032 Reset SHALL force state IDLE, blk_valid = 0, blk_data = 0, pid_err = 0, crc_err = 0, drop_cnt = 0, busy = 0, crc_reg = 16'hFFFF.
REQ-033 Reset asserted mid-CHECK or mid-HOLD SHALL discard the packet without an error pulse and without incrementing drop_cnt.
REQ-034 pkt_done coincident with reset SHALL be ignored.

Configuration
REQ-035 Macro USB_CRC16_CHECK_EN defined: CHECK state and CRC logic are present as specified.
REQ-036 USB_CRC16_CHECK_EN undefined: a valid PID goes directly to HOLD (blk_valid 2 cycles after pkt_done), crc_err is tied to 0, and no CRC logic is synthesized.

Verification
REQ-037 PID 8'hC3, data 64'h0123_4567_89AB_CDEF, crc16 from the bench model, blk_ready = 1 -> blk_valid at cycle 66 with blk_data = 64'h0123456789ABCDEF; one-cycle handshake; drop_cnt = 0.
REQ-038 PID 8'hC4 (nibbles not complementary) -> pid_err pulse at cycle 1; drop_cnt = 1; blk_valid never asserted.
REQ-039 Valid PID 8'h4B, crc16 = model value ^ 16'h0001 -> crc_err pulse at cycle 65; drop_cnt = 1; state back to IDLE.
REQ-040 Good packet with blk_ready = 0 for 10 cycles after blk_valid, then a second pkt_done -> blk_data stable throughout; drop_cnt = 1; handshake when blk_ready rises.
REQ-041 drop_cnt preloaded to 255 via 255 bad-PID packets, then one more bad PID -> drop_cnt stays 8'hFF.
REQ-042 Reset pulsed at CHECK cycle 30 -> all outputs at reset values next cycle, no error pulse, next good packet accepted normally.
